// File: rtl/rx_bit_packer.sv
// Packs the demapped 2-bit RX stream MSB-first into bytes, tags the first byte of
// each OFDM symbol, and buffers bytes in a first-word-fall-through FIFO for the host.
module rx_bit_packer #(
    parameter int raw_symbol_length_g = 128,
    parameter int fifo_depth_g        = 16,
    localparam int lvl_w              = $clog2(fifo_depth_g + 1)
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    input  logic             sys_init,
    input  logic [1:0]       rx_rcv_data,
    input  logic             rx_rcv_data_valid,
    output logic [7:0]       byte_data,
    output logic             byte_sof,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [lvl_w-1:0] fifo_level,
    output logic             overflow
);

    localparam int ptr_w = $clog2(fifo_depth_g);
    localparam int sc_w  = $clog2(raw_symbol_length_g + 1);

    logic [5:0]       sr;
    logic [1:0]       dibit_cnt;
    logic [sc_w-1:0]  sym_cnt;
    logic [sc_w-1:0]  sym_next;
    logic [8:0]       mem [fifo_depth_g];
    logic [ptr_w-1:0] wr_ptr;
    logic [ptr_w-1:0] rd_ptr;
    logic [lvl_w-1:0] level;

    logic       wr_req;
    logic       wr_ok;
    logic       pop;
    logic       full;
    logic [8:0] wr_word;

    // Handshake: a byte transfers on any rising edge where byte_valid and byte_ready
    // are both high; byte_valid never depends on byte_ready, and the head entry holds
    // steady until it is taken.
    always_comb begin
        sym_next = sym_cnt + sc_w'(2);
        wr_req   = rx_rcv_data_valid && (dibit_cnt == 2'd3);
        wr_word  = {(sym_cnt == sc_w'(6)), sr, rx_rcv_data};
        pop      = (level != '0) && byte_ready;
        full     = (level == lvl_w'(fifo_depth_g));
        // A full FIFO still takes the write when the head leaves in the same cycle.
        wr_ok    = wr_req && (!full || pop);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rstn || sys_init) begin
            sr        <= '0;
            dibit_cnt <= '0;
            sym_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
        end else begin
            if (rx_rcv_data_valid) begin
                sr        <= {sr[3:0], rx_rcv_data};
                dibit_cnt <= dibit_cnt + 2'd1;
                sym_cnt   <= (sym_next == sc_w'(raw_symbol_length_g)) ? '0 : sym_next;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_w'(1);
            end
            unique case ({wr_ok, pop})
                2'b10:   level <= level + lvl_w'(1);
                2'b01:   level <= level - lvl_w'(1);
                default: level <= level;
            endcase
            if (wr_req && !wr_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; only pointers and level define its contents.
    always_ff @(posedge sys_clk) begin
        if (sys_rstn && !sys_init && wr_ok) begin
            mem[wr_ptr] <= wr_word;
        end
    end

    always_comb begin
        byte_valid = (level != '0);
        byte_data  = byte_valid ? mem[rd_ptr][7:0] : 8'h00;
        byte_sof   = byte_valid ? mem[rd_ptr][8] : 1'b0;
        fifo_level = level;
    end

endmodule

// File: tb/tb_rx_bit_packer.sv
// Self-checking bench for rx_bit_packer: vector table plus hand-written corner
// sequences, with an expected-byte queue drained by a negedge monitor.
module tb_rx_bit_packer;
    localparam int sym_len       = 128;
    localparam int depth         = 16;
    localparam int lvl_w         = $clog2(depth + 1);
    localparam int bytes_per_sym = sym_len / 8;

    logic             sys_clk = 1'b0;
    logic             sys_rstn = 1'b0;
    logic             sys_init = 1'b0;
    logic [1:0]       rx_rcv_data = 2'd0;
    logic             rx_rcv_data_valid = 1'b0;
    logic [7:0]       byte_data;
    logic             byte_sof;
    logic             byte_valid;
    logic             byte_ready = 1'b0;
    logic [lvl_w-1:0] fifo_level;
    logic             overflow;

    int         checks = 0;
    int         errors = 0;
    int         mon_count = 0;
    int         byte_idx = 0;
    int         mc0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    logic [7:0] b;

    typedef struct {
        logic [1:0] d0, d1, d2, d3;
        logic [7:0] exp_byte;
        logic       exp_sof;
    } vec_t;
    vec_t vecs[8];

    rx_bit_packer #(
        .raw_symbol_length_g(sym_len),
        .fifo_depth_g(depth)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rstn(sys_rstn),
        .sys_init(sys_init),
        .rx_rcv_data(rx_rcv_data),
        .rx_rcv_data_valid(rx_rcv_data_valid),
        .byte_data(byte_data),
        .byte_sof(byte_sof),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted byte is compared with the queue head.
    always @(negedge sys_clk) begin
        if (sys_rstn && !sys_init && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h expected none", byte_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("byte_data", 32'(byte_data), 32'(mon_exp[7:0]));
                chk("byte_sof", 32'(byte_sof), 32'(mon_exp[8]));
            end
            mon_count++;
        end
    end

    task automatic send_dibit(input logic [1:0] d);
        @(posedge sys_clk);
        #1;
        sys_init          = 1'b0;
        rx_rcv_data       = d;
        rx_rcv_data_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            rx_rcv_data_valid = 1'b0;
            sys_init          = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [7:0] v, input logic keep);
        if (keep) exp_q.push_back({((byte_idx % bytes_per_sym) == 0), v});
        byte_idx++;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic keep);
        send_dibit(v[7:6]);
        send_dibit(v[5:4]);
        send_dibit(v[3:2]);
        send_dibit(v[1:0]);
        push_exp(v, keep);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            @(negedge sys_clk);
            n++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic do_init();
        @(posedge sys_clk);
        #1;
        sys_init          = 1'b1;
        rx_rcv_data_valid = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_init = 1'b0;
        byte_idx = 0;
    endtask

    initial begin
        vecs[0] = '{2'd3, 2'd0, 2'd2, 2'd1, 8'hC9, 1'b1};
        vecs[1] = '{2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0};
        vecs[2] = '{2'd3, 2'd3, 2'd3, 2'd3, 8'hFF, 1'b0};
        vecs[3] = '{2'd1, 2'd1, 2'd1, 2'd1, 8'h55, 1'b0};
        vecs[4] = '{2'd2, 2'd2, 2'd2, 2'd2, 8'hAA, 1'b0};
        vecs[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 8'h1B, 1'b0};
        vecs[6] = '{2'd3, 2'd2, 2'd1, 2'd0, 8'hE4, 1'b0};
        vecs[7] = '{2'd2, 2'd0, 2'd0, 2'd1, 8'h81, 1'b0};

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1 sys_rstn = 1'b1;
        @(negedge sys_clk);
        chk("rst_valid", 32'(byte_valid), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_data", 32'(byte_data), 32'd0);
        chk("rst_sof", 32'(byte_sof), 32'd0);

        // Single byte with gapped valids: latency and one-cycle valid
        byte_ready = 1'b1;
        send_dibit(2'd3); idle(1);
        send_dibit(2'd0); idle(1);
        send_dibit(2'd2); idle(1);
        send_dibit(2'd1);
        exp_q.push_back({1'b1, 8'hC9});
        @(negedge sys_clk);
        chk("t1_not_early", 32'(byte_valid), 32'd0);
        idle(1);
        @(negedge sys_clk);
        chk("t1_valid", 32'(byte_valid), 32'd1);
        chk("t1_data", 32'(byte_data), 32'hC9);
        chk("t1_sof", 32'(byte_sof), 32'd1);
        idle(1);
        @(negedge sys_clk);
        chk("t1_one_cycle", 32'(byte_valid), 32'd0);
        wait_drain(20);

        // Vector table, back-to-back dibits
        do_init();
        for (int i = 0; i < 8; i++) begin
            send_dibit(vecs[i].d0);
            send_dibit(vecs[i].d1);
            send_dibit(vecs[i].d2);
            send_dibit(vecs[i].d3);
            exp_q.push_back({vecs[i].exp_sof, vecs[i].exp_byte});
        end
        idle(1);
        wait_drain(50);
        chk("tbl_level", 32'(fifo_level), 32'd0);

        // Two full symbols of random data
        do_init();
        mc0 = mon_count;
        for (int k = 0; k < 2 * bytes_per_sym; k++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1);
        end
        idle(1);
        wait_drain(200);
        chk("t2_count", 32'(mon_count - mc0), 32'd32);
        chk("t2_overflow", 32'(overflow), 32'd0);
        chk("t2_level", 32'(fifo_level), 32'd0);

        // Fill past full with no consumer
        do_init();
        byte_ready = 1'b0;
        for (int k = 0; k < depth + 1; k++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, k < depth);
        end
        idle(1);
        @(negedge sys_clk);
        chk("t3_level_full", 32'(fifo_level), 32'(depth));
        chk("t3_overflow", 32'(overflow), 32'd1);
        mc0 = mon_count;
        byte_ready = 1'b1;
        wait_drain(100);
        chk("t3_drained", 32'(mon_count - mc0), 32'(depth));
        chk("t3_level_empty", 32'(fifo_level), 32'd0);
        chk("t3_sticky", 32'(overflow), 32'd1);

        // Full FIFO with a pop in the same cycle as the next write
        do_init();
        byte_ready = 1'b0;
        for (int k = 0; k < depth; k++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1);
        end
        b = 8'($urandom_range(0, 255));
        send_dibit(b[7:6]);
        send_dibit(b[5:4]);
        send_dibit(b[3:2]);
        send_dibit(b[1:0]);
        byte_ready = 1'b1;
        push_exp(b, 1'b1);
        @(posedge sys_clk);
        #1;
        byte_ready        = 1'b0;
        rx_rcv_data_valid = 1'b0;
        @(negedge sys_clk);
        chk("t4_level", 32'(fifo_level), 32'(depth));
        chk("t4_overflow", 32'(overflow), 32'd0);
        byte_ready = 1'b1;
        wait_drain(100);
        chk("t4_level_empty", 32'(fifo_level), 32'd0);

        // Mid-byte sys_init, with a dibit offered during the init cycle
        do_init();
        byte_ready = 1'b0;
        send_dibit(2'd3);
        send_dibit(2'd3);
        @(posedge sys_clk);
        #1;
        sys_init          = 1'b1;
        rx_rcv_data       = 2'd3;
        rx_rcv_data_valid = 1'b1;
        byte_idx = 0;
        send_dibit(2'd0);
        send_dibit(2'd1);
        send_dibit(2'd2);
        send_dibit(2'd3);
        push_exp(8'h1B, 1'b1);
        idle(1);
        @(negedge sys_clk);
        chk("t5_level", 32'(fifo_level), 32'd1);
        chk("t5_data", 32'(byte_data), 32'h1B);
        chk("t5_sof", 32'(byte_sof), 32'd1);
        byte_ready = 1'b1;
        wait_drain(20);

        // Reset while holding bytes and overflow
        do_init();
        byte_ready = 1'b0;
        for (int k = 0; k < depth + 1; k++) begin
            b = 8'($urandom_range(0, 255));
            send_byte(b, k < depth);
        end
        idle(1);
        byte_ready = 1'b1;
        repeat (11) @(posedge sys_clk);
        #1 byte_ready = 1'b0;
        @(negedge sys_clk);
        chk("t6_level5", 32'(fifo_level), 32'd5);
        chk("t6_ovf_set", 32'(overflow), 32'd1);
        @(posedge sys_clk);
        #1;
        sys_rstn = 1'b0;
        exp_q.delete();
        @(posedge sys_clk);
        #1;
        sys_rstn = 1'b1;
        byte_idx = 0;
        @(negedge sys_clk);
        chk("t6_valid", 32'(byte_valid), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_overflow", 32'(overflow), 32'd0);
        send_dibit(2'd2);
        send_dibit(2'd2);
        send_dibit(2'd1);
        send_dibit(2'd1);
        push_exp(8'hA5, 1'b1);
        byte_ready = 1'b1;
        idle(1);
        wait_drain(20);
        chk("t6_level_end", 32'(fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
